sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares one SDRAM controller port between the SD-card loader (write-only, port LD) and two
//  read streams (RD0 = audio sample fetch, RD1 = aux/graphics fetch).
//  One transaction is outstanding at a time. LD has fixed top priority; RD0/RD1 are round-robin.
//  Sits between the requesters and the SDRAM controller's req/op_begun/rdata_valid interface.
// PARAMETERS
//  ADDR_W        25    word address width
//  DATA_W        16    data word width
//  RD_GATE_INIT  1     1: RD0/RD1 requests ignored until ld_init_done=1
//  WDOG_CYCLES   1024  watchdog limit in clk50 cycles (used only with ARB_WATCHDOG_EN)
// PORTS
//  clk50           in   1       system clock
//  reset           in   1       synchronous, active-high
//  ld_we           in   1       loader write request, held until ld_op_begun
//  ld_address      in   ADDR_W  loader word address
//  ld_data         in   DATA_W  loader write data
//  ld_init_done    in   1       loader finished the whole image
//  ld_op_begun     out  1       one-cycle accept pulse to loader
//  rdN_req         in   1       read request N=0,1, held with rdN_addr until rdN_ack
//  rdN_addr        in   ADDR_W  read word address
//  rdN_ack         out  1       one-cycle accept pulse
//  rdN_valid       out  1       one-cycle read-data strobe
//  rdN_data        out  DATA_W  read data, meaningful when rdN_valid=1
//  mem_req         out  1       request to controller
//  mem_we          out  1       1=write, 0=read
//  mem_addr        out  ADDR_W  word address to controller
//  mem_wdata       out  DATA_W  write data to controller
//  mem_op_begun    in   1       controller accepted the current request
//  mem_rdata       in   DATA_W  controller read data
//  mem_rdata_valid in   1       controller read data strobe
//  arb_timeout     out  1       sticky watchdog flag
// BEHAVIOUR
//  - Reset: state=IDLE, owner=NONE, last_rd=1 (RD0 wins the first tie). All outputs are 0.
//  - A reset mid-transaction aborts it. A later mem_rdata_valid is dropped because owner=NONE.
//  - FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
//  - IDLE: owner is registered in the same cycle.
//    - If ld_we=1, owner=LD and go to WR_ISSUE.
//    - Else, if an enabled read request is pending, pick RD0/RD1 and go to RD_ISSUE.
//    - A read request is enabled when RD_GATE_INIT=0 or ld_init_done=1.
//    - If both reads request, grant the one with index != last_rd.
//    - last_rd is updated at the grant.
//  - WR_ISSUE / RD_ISSUE: mem_req=1.
//    - mem_we=1 only in WR_ISSUE.
//    - mem_addr and mem_wdata are muxed combinationally from the owner's inputs.
//    - When mem_op_begun=1, pulse the owner's ld_op_begun/rdN_ack combinationally in that cycle.
//    - WR_ISSUE then goes to IDLE. RD_ISSUE then goes to RD_WAIT.
//  - RD_WAIT: rdN_valid=mem_rdata_valid and rdN_data=mem_rdata for the owner (zero latency).
//    - On mem_rdata_valid go to IDLE and set owner=NONE.
//  - A request dropped before its ack is a protocol violation; behaviour is undefined.
//  - Grant latency: a request seen in IDLE cycle N gives mem_req=1 in cycle N+1.
//    - Minimum write cycle is 2 clocks when mem_op_begun arrives the same cycle as mem_req.
//  - LD pre-empts only at IDLE, never inside a transaction. Reads starve while LD streams; that is intended.
//  - rdN_data = mem_rdata always. Only rdN_valid is gated.
// CONFIGURATION
//  - ARB_WATCHDOG_EN defined:
//    - A counter clears on entry to each ISSUE/WAIT state and increments each cycle in it.
//    - At WDOG_CYCLES-1 the FSM forces IDLE, sets owner=NONE and sets arb_timeout=1.
//    - arb_timeout is sticky until reset. The requester still holds its request and is re-arbitrated.
//  - ARB_WATCHDOG_EN undefined: no counter, arb_timeout tied to 0, waits indefinitely.
// TESTING
//  - LD write, addr 0x000010, data 0xBEEF, op_begun 3 clocks after mem_req:
//    -> mem_we=1 with that addr/data; one ld_op_begun pulse; back to IDLE.
//  - RD0 and RD1 request together after init_done, 4 reads each:
//    -> grants alternate RD0,RD1,RD0,...; each rdN_valid pulse only on its owner.
//  - RD_GATE_INIT=1, rd0_req=1, ld_init_done=0:
//    -> no mem_req; after init_done rises, grant on the next cycle.
//  - ld_we and rd0_req both high in IDLE
//    -> LD granted first, RD0 after LD's op_begun.
//  - Reset asserted in RD_WAIT, then mem_rdata_valid=1:
//    -> rd0_valid stays 0; all outputs 0.
//  - ARB_WATCHDOG_EN, WDOG_CYCLES=16, mem_op_begun never asserted:
//    -> after 16 cycles arb_timeout=1 and the FSM re-issues.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between the loader (LD, top priority) and two round-robin read streams.
// Optional watchdog under `ARB_WATCHDOG_EN`: a stalled transaction is abandoned after WDOG_CYCLES and re-arbitrated.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int RD_GATE_INIT = 1,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_address,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_init_done,
  output logic              ld_op_begun,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_ack,
  output logic              rd0_valid,
  output logic [DATA_W-1:0] rd0_data,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_ack,
  output logic              rd1_valid,
  output logic [DATA_W-1:0] rd1_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_op_begun,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              arb_timeout
);

  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_LD, OWN_RD0, OWN_RD1} owner_t;

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic   last_rd_q, last_rd_d;
  logic   rd_en;

  assign rd_en    = (RD_GATE_INIT == 0) || ld_init_done;
  assign rd0_data = mem_rdata;
  assign rd1_data = mem_rdata;

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_q, wdog_d;
  logic          timeout_q;
  logic          wdog_trip;

  // Counter restarts whenever a new ISSUE/WAIT state is entered.
  assign wdog_d      = (state_q == IDLE || state_d != state_q) ? '0 : wdog_q + 1'b1;
  assign arb_timeout = timeout_q;

  always_ff @(posedge clk50) begin
    if (reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_q | wdog_trip;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES != 0);
  assign arb_timeout = 1'b0;
`endif

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      last_rd_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_rd_d   = last_rd_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ld_op_begun = 1'b0;
    rd0_ack     = 1'b0;
    rd1_ack     = 1'b0;
    rd0_valid   = 1'b0;
    rd1_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_we) begin
          owner_d = OWN_LD;
          state_d = WR_ISSUE;
        end else if (rd_en && (rd0_req || rd1_req)) begin
          // On a tie the stream that did not win last time gets the grant.
          if (rd0_req && (!rd1_req || last_rd_q)) begin
            owner_d   = OWN_RD0;
            last_rd_d = 1'b0;
          end else begin
            owner_d   = OWN_RD1;
            last_rd_d = 1'b1;
          end
          state_d = RD_ISSUE;
        end
      end
      WR_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_address;
        mem_wdata = ld_data;
        if (mem_op_begun) begin
          ld_op_begun = 1'b1;
          state_d     = IDLE;
          owner_d     = OWN_NONE;
        end
      end
      RD_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = (owner_q == OWN_RD1) ? rd1_addr : rd0_addr;
        if (mem_op_begun) begin
          rd0_ack = (owner_q == OWN_RD0);
          rd1_ack = (owner_q == OWN_RD1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        rd0_valid = mem_rdata_valid && (owner_q == OWN_RD0);
        rd1_valid = mem_rdata_valid && (owner_q == OWN_RD1);
        if (mem_rdata_valid) begin
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
    endcase
`ifdef ARB_WATCHDOG_EN
    wdog_trip = 1'b0;
    if (state_q != IDLE && wdog_q == CW'(WDOG_CYCLES - 1) && state_d == state_q) begin
      wdog_trip = 1'b1;
      state_d   = IDLE;
      owner_d   = OWN_NONE;
    end
`endif
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected grants are queued as stimulus is driven, checked at each accept.
module tb_sdram_port_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;

  logic          clk50 = 1'b0;
  logic          reset;
  logic          ld_we, ld_init_done, ld_op_begun;
  logic [AW-1:0] ld_address, rd0_addr, rd1_addr, mem_addr;
  logic [DW-1:0] ld_data, rd0_data, rd1_data, mem_wdata, mem_rdata;
  logic          rd0_req, rd0_ack, rd0_valid, rd1_req, rd1_ack, rd1_valid;
  logic          mem_req, mem_we, mem_op_begun, mem_rdata_valid, arb_timeout;

  always #10 clk50 = ~clk50;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_GATE_INIT(1), .WDOG_CYCLES(16)) dut (
    .clk50(clk50), .reset(reset),
    .ld_we(ld_we), .ld_address(ld_address), .ld_data(ld_data),
    .ld_init_done(ld_init_done), .ld_op_begun(ld_op_begun),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ack(rd0_ack),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ack(rd1_ack),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_op_begun(mem_op_begun), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .arb_timeout(arb_timeout)
  );

  localparam logic [2:0] W_LD  = 3'b001;
  localparam logic [2:0] W_RD0 = 3'b010;
  localparam logic [2:0] W_RD1 = 3'b100;

  typedef struct {
    logic [2:0]    who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   rd0_left = 0;
  int   rd1_left = 0;
  int   last_wait = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [9:0] ctrl_outs();
    return {mem_req, mem_we, ld_op_begun, rd0_ack, rd1_ack, rd0_valid, rd1_valid,
            arb_timeout, |mem_addr, |mem_wdata};
  endfunction

  task automatic push(input logic [2:0] who, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata);
    exp_t e;
    e.who = who; e.we = we; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ld_we = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
    mem_op_begun = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    check("reset_outs", ctrl_outs(), 0);
    @(posedge clk50); #1 reset = 1'b0;
  endtask

  // Acts as the controller: waits for mem_req, accepts after dly cycles, optionally returns read data.
  task automatic serve(input int dly, input logic [DW-1:0] rdata, input bit do_data);
    exp_t e;
    last_wait = 0;
    do begin
      @(negedge clk50);
      last_wait++;
    end while (!mem_req && last_wait < 60);
    if (!mem_req) begin
      check("req_timeout", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("exp_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    for (int i = 0; i < dly; i++) begin
      check("no_early_ack", {ld_op_begun, rd0_ack, rd1_ack}, 0);
      @(negedge clk50);
    end
    mem_op_begun = 1'b1;
    #1;
    check("ack_who", {rd1_ack, rd0_ack, ld_op_begun}, e.who);
    check("mem_we", mem_we, e.we);
    check("mem_addr", mem_addr, e.addr);
    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
    @(posedge clk50); #1 mem_op_begun = 1'b0;
    if (e.who[0]) ld_we = 1'b0;
    if (e.who[1]) begin
      rd0_left--;
      if (rd0_left <= 0) rd0_req = 1'b0; else rd0_addr = rd0_addr + 1'b1;
    end
    if (e.who[2]) begin
      rd1_left--;
      if (rd1_left <= 0) rd1_req = 1'b0; else rd1_addr = rd1_addr + 1'b1;
    end
    if (!e.we && do_data) begin
      @(negedge clk50);
      mem_rdata = rdata; mem_rdata_valid = 1'b1;
      #1;
      check("rd_valid", {rd1_valid, rd0_valid}, e.who[2:1]);
      check("rd_data", e.who[1] ? rd0_data : rd1_data, rdata);
      @(posedge clk50); #1 mem_rdata_valid = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   seen;
    bit   tb_last;
    int   n;
    int   n0;
    int   n1;
    reset = 1'b1;
    ld_we = 1'b0; ld_address = '0; ld_data = '0; ld_init_done = 1'b0;
    rd0_req = 1'b0; rd0_addr = '0; rd1_req = 1'b0; rd1_addr = '0;
    mem_op_begun = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0;
    do_reset();

    // Loader write, accepted three cycles after mem_req.
    ld_address = 25'h000010; ld_data = 16'hBEEF; ld_we = 1'b1;
    push(W_LD, 1'b1, 25'h000010, 16'hBEEF);
    serve(3, '0, 1'b0);
    check("ld_grant_lat", last_wait, 2);
    @(negedge clk50);
    check("ld_back_idle", mem_req, 0);

    // Read gated until the image is loaded.
    rd0_addr = 25'h40; rd0_left = 1; rd0_req = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk50);
      seen |= mem_req;
    end
    check("gate_hold", seen, 0);
    @(posedge clk50); #1 ld_init_done = 1'b1;
    push(W_RD0, 1'b0, 25'h40, '0);
    serve(1, 16'h1234, 1'b1);
    check("gate_lat", last_wait, 2);

    // Loader beats a simultaneous read.
    @(posedge clk50); #1;
    ld_address = 25'h20; ld_data = 16'h1111; ld_we = 1'b1;
    rd0_addr = 25'h30; rd0_left = 1; rd0_req = 1'b1;
    push(W_LD, 1'b1, 25'h20, 16'h1111);
    push(W_RD0, 1'b0, 25'h30, '0);
    serve(0, '0, 1'b0);
    serve(2, 16'h2222, 1'b1);

    // Both reads held: round-robin from a fresh reset.
    do_reset();
    rd0_addr = 25'h100; rd1_addr = 25'h200; rd0_left = 4; rd1_left = 4;
    tb_last = 1'b1; n0 = 0; n1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (tb_last) begin
        push(W_RD0, 1'b0, 25'h100 + 25'(n0), '0); n0++;
      end else begin
        push(W_RD1, 1'b0, 25'h200 + 25'(n1), '0); n1++;
      end
      tb_last = ~tb_last;
    end
    rd0_req = 1'b1; rd1_req = 1'b1;
    for (int k = 0; k < 8; k++) serve(k % 3, 16'hA000 + 16'(k), 1'b1);
    check("rr_queue_empty", exp_q.size(), 0);

    // Reset while waiting for read data drops the late strobe.
    @(posedge clk50); #1;
    rd0_addr = 25'h77; rd0_left = 1; rd0_req = 1'b1;
    push(W_RD0, 1'b0, 25'h77, '0);
    serve(0, '0, 1'b0);
    reset = 1'b1;
    @(posedge clk50); #1 reset = 1'b0;
    @(negedge clk50);
    mem_rdata = '0; mem_rdata_valid = 1'b1;
    #1;
    check("rst_drop_valid", rd0_valid, 0);
    check("rst_outs", ctrl_outs(), 0);
    @(posedge clk50); #1 mem_rdata_valid = 1'b0;

    // Controller never accepts.
    ld_address = 25'h55; ld_data = 16'hA5A5; ld_we = 1'b1;
`ifdef ARB_WATCHDOG_EN
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk50);
      n++;
    end
    n = 0;
    while (mem_req && n < 100) begin
      n++;
      @(negedge clk50);
    end
    check("wdog_len", n, 16);
    check("wdog_idle", mem_req, 0);
    check("wdog_flag", arb_timeout, 1);
    @(negedge clk50);
    check("wdog_reissue", mem_req, 1);
    push(W_LD, 1'b1, 25'h55, 16'hA5A5);
    serve(0, '0, 1'b0);
    check("wdog_sticky", arb_timeout, 1);
`else
    n = 0;
    repeat (40) begin
      @(negedge clk50);
      if (mem_req) n++;
    end
    check("stall_req_held", n, 39);
    check("no_timeout", arb_timeout, 0);
    push(W_LD, 1'b1, 25'h55, 16'hA5A5);
    serve(0, '0, 1'b0);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
